bdm_s_boot_mem: RTL and testbench

BDM_S_BOOT_MEM -- requirements
Module: bdm_s_boot_mem

---
 rtl/bdm_s_boot_mem_if.sv | 29 ++
 rtl/bdm_s_boot_mem.sv | 112 +++++++++++
 tb/tb_bdm_s_boot_mem.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bdm_s_boot_mem_if.sv
// bdm_s_boot_mem_if: AXI4-Lite bus between the boot-code loader (master) and the boot RAM (slave).
interface bdm_s_boot_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid, awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid, wready;
    logic [1:0]      bresp;
    logic            bvalid, bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid, arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid, rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/bdm_s_boot_mem.sv
// bdm_s_boot_mem: AXI4-Lite boot-code RAM plus a CTRL word whose READY bit drives boot_code_ready.
// Define BDM_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module bdm_s_boot_mem #(
    parameter logic [31:0] C_BOOT_CODE_ADDR = 32'hB000_0000,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_WORDS = 256
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    bdm_s_boot_mem_if.slave  s_axi,
    output logic             boot_code_ready
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int IW = $clog2(C_MEM_WORDS);
    localparam logic [AW-1:0] BASE = AW'(C_BOOT_CODE_ADDR);
    localparam logic [AW-3:0] BASE_W = BASE[AW-1:2];
    localparam logic [AW-3:0] NWORDS = (AW-2)'(C_MEM_WORDS);
`ifdef BDM_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic [DW-1:0]   mem [C_MEM_WORDS];
    logic            live_q;
    logic            aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d, ready_q, ready_d;
    logic [AW-1:0]   aw_addr_q, aw_addr_d;
    logic [DW-1:0]   w_data_q, w_data_d, rdata_q, rdata_d, rd_word;
    logic [DW/8-1:0] w_strb_q, w_strb_d;
    logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
    logic [AW-3:0]   aw_woff, ar_woff;
    logic            aw_hs, w_hs, ar_hs, commit, wr_ram, wr_ctrl, rd_ram, rd_ctrl;
    logic            unused_ok;

    // live_q keeps every READY low until the first edge after reset release
    assign s_axi.awready = live_q && !aw_full_q && !bvalid_q;
    assign s_axi.wready  = live_q && !w_full_q && !bvalid_q;
    assign s_axi.arready = live_q && !rvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign boot_code_ready = ready_q;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0], aw_addr_q[1:0]};

    assign aw_woff = aw_addr_q[AW-1:2] - BASE_W;
    assign ar_woff = s_axi.araddr[AW-1:2] - BASE_W;
    assign wr_ram  = aw_woff < NWORDS;
    assign wr_ctrl = aw_woff == NWORDS;
    assign rd_ram  = ar_woff < NWORDS;
    assign rd_ctrl = ar_woff == NWORDS;
    assign rd_word = rd_ram ? mem[ar_woff[IW-1:0]] : rd_ctrl ? DW'({16'hB00D, 15'd0, ready_q}) : '0;

    always_comb begin
        aw_hs     = s_axi.awvalid && s_axi.awready;
        w_hs      = s_axi.wvalid && s_axi.wready;
        ar_hs     = s_axi.arvalid && s_axi.arready;
        commit    = aw_full_q && w_full_q;
        aw_full_d = !commit && (aw_full_q || aw_hs);
        w_full_d  = !commit && (w_full_q || w_hs);
        aw_addr_d = aw_hs ? s_axi.awaddr : aw_addr_q;
        w_data_d  = w_hs ? s_axi.wdata : w_data_q;
        w_strb_d  = w_hs ? s_axi.wstrb : w_strb_q;
        bvalid_d  = commit || (bvalid_q && !s_axi.bready);
        bresp_d   = commit ? ((wr_ram || wr_ctrl) ? 2'b00 : OOR_RESP) : bresp_q;
        ready_d   = (commit && wr_ctrl && w_strb_q[0]) ? w_data_q[0] : ready_q;
        rvalid_d  = ar_hs || (rvalid_q && !s_axi.rready);
        rdata_d   = ar_hs ? rd_word : rdata_q;
        rresp_d   = ar_hs ? ((rd_ram || rd_ctrl) ? 2'b00 : OOR_RESP) : rresp_q;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            live_q    <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            live_q    <= 1'b1;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // RAM keeps its image across reset; a same-edge read sees the old word
    always_ff @(posedge S_AXI_ACLK) begin
        if (commit && wr_ram)
            for (int i = 0; i < DW/8; i++)
                if (w_strb_q[i]) mem[aw_woff[IW-1:0]][8*i +: 8] <= w_data_q[8*i +: 8];
    end
endmodule

// File: tb/tb_bdm_s_boot_mem.sv
// tb_bdm_s_boot_mem: directed plus random AXI4-Lite traffic checked against a word-array model of the boot RAM.
module tb_bdm_s_boot_mem;
    localparam logic [31:0] BASE = 32'hB000_0000;
    localparam int WORDS = 256;
`ifdef BDM_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic boot_code_ready;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] ref_mem [WORDS];
    logic ref_ready = 1'b0;

    bdm_s_boot_mem_if #(.AW(32), .DW(32)) bus();

    bdm_s_boot_mem dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi(bus),
        .boot_code_ready(boot_code_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] offs(input logic [31:0] a);
        return (a & ~32'h3) - BASE;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [31:0] o;
        o = offs(a);
        if (o < 4 * WORDS) return ref_mem[o[9:2]];
        if (o == 4 * WORDS) return {16'hB00D, 15'd0, ref_ready};
        return 32'd0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
        logic [31:0] o;
        o = offs(a);
        r = OOR;
        if (o < 4 * WORDS) begin
            for (int i = 0; i < 4; i++) if (s[i]) ref_mem[o[9:2]][8*i +: 8] = d[8*i +: 8];
            r = 2'b00;
        end else if (o == 4 * WORDS) begin
            if (s[0]) ref_ready = d[0];
            r = 2'b00;
        end
    endtask

    // w_delay: cycles W trails AW (negative: W leads). hold < 0 leaves the B response pending.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_delay, input int hold, input string tag);
        int t, lat, aw_at, w_at;
        bit aw_done, w_done, aw_hs, w_hs;
        logic [1:0] er;
        t = 0; lat = 0; aw_done = 0; w_done = 0;
        aw_at = w_delay < 0 ? -w_delay : 0;
        w_at = w_delay < 0 ? 0 : w_delay;
        while (!(aw_done && w_done) && t < 40) begin
            bus.awaddr = a; bus.awprot = 3'($urandom);
            bus.wdata = d; bus.wstrb = s;
            bus.awvalid = !aw_done && t >= aw_at;
            bus.wvalid = !w_done && t >= w_at;
            aw_hs = bus.awvalid && bus.awready;
            w_hs = bus.wvalid && bus.wready;
            step();
            aw_done |= aw_hs; w_done |= w_hs; t++;
        end
        bus.awvalid = 0; bus.wvalid = 0;
        check({tag, ".handshake"}, {31'd0, aw_done && w_done}, 1);
        while (!bus.bvalid && lat < 20) begin step(); lat++; end
        check({tag, ".blat"}, lat, 1);
        model_write(a, d, s, er);
        check({tag, ".bresp"}, bus.bresp, er);
        for (int k = 0; k < hold; k++) begin
            step();
            check({tag, ".bhold"}, {bus.bvalid, bus.bresp, bus.awready, bus.wready}, {1'b1, er, 2'b00});
        end
        if (hold >= 0) begin
            bus.bready = 1; step(); bus.bready = 0;
            check({tag, ".bdone"}, bus.bvalid, 0);
            check({tag, ".boot_rdy"}, boot_code_ready, ref_ready);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int hold, input string tag);
        int t;
        bit done;
        logic [31:0] ed;
        logic [1:0] er;
        ed = exp_rd(a);
        er = offs(a) <= 4 * WORDS ? 2'b00 : OOR;
        t = 0; done = 0;
        bus.araddr = a; bus.arprot = 3'($urandom); bus.arvalid = 1;
        while (!done && t < 20) begin done = bus.arready; step(); t++; end
        bus.arvalid = 0;
        check({tag, ".arhs"}, {31'd0, done}, 1);
        check({tag, ".rvalid"}, bus.rvalid, 1);
        check({tag, ".rdata"}, bus.rdata, ed);
        check({tag, ".rresp"}, bus.rresp, er);
        for (int k = 0; k < hold; k++) begin
            step();
            check({tag, ".rhold"}, {bus.rvalid, bus.arready}, 2'b10);
            check({tag, ".rhold_data"}, bus.rdata, ed);
        end
        bus.rready = 1; step(); bus.rready = 0;
        check({tag, ".rdone"}, bus.rvalid, 0);
    endtask

    initial begin
        logic [31:0] old, a;
        logic [1:0] er;
        int kind;
        bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
        #2 rst_n = 0;
        step(); step();
        check("rst.ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
        check("rst.valid", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 6'd0);
        check("rst.rdata", bus.rdata, 0);
        check("rst.boot_rdy", boot_code_ready, 0);
        rst_n = 1;
        #1 check("rst.rel_pre_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
        step();
        check("rst.rel_first_edge", {bus.awready, bus.wready, bus.arready}, 3'b111);

        for (int i = 0; i < WORDS; i++) do_write(BASE + 4 * i, $urandom, 4'hF, 0, 0, "init");

        do_write(32'hB000_0010, 32'h1234_5678, 4'hF, 3, 0, "aw_then_w");
        do_read(32'hB000_0010, 0, "aw_then_w.rd");
        do_write(32'hB000_0004, 32'hFFFF_FFFF, 4'hF, 0, 0, "strb.pre");
        do_write(32'hB000_0004, 32'hAABB_CCDD, 4'b0101, 0, 0, "strb");
        do_read(32'hB000_0004, 0, "strb.rd");
        do_write(32'hB000_0024, 32'hCAFE_0001, 4'hF, -2, 0, "w_first");
        do_read(32'hB000_0024, 0, "w_first.rd");

        do_write(32'hB000_0400, 32'h0000_0001, 4'h1, 0, 0, "ctrl");
        do_read(32'hB000_0400, 0, "ctrl.rd");

        do_read(32'hB000_0800, 0, "oor.rd");
        do_write(32'hB000_0800, 32'hDEAD_BEEF, 4'hF, 0, 0, "oor.wr");
        do_read(32'hB000_0000, 0, "oor.ram0");
        do_read(32'hB000_03FC, 0, "oor.ram_last");
        do_read(32'hAFFF_FFFC, 0, "oor.below");

        do_write(32'hB000_0030, 32'h5555_AAAA, 4'hF, 1, 5, "bhold");
        do_read(32'hB000_0030, 5, "rhold");

        // write commit and AR handshake on the same edge
        old = ref_mem[5];
        bus.awaddr = BASE + 20; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        step();
        bus.awvalid = 0; bus.wvalid = 0; bus.araddr = BASE + 20; bus.arvalid = 1;
        step();
        bus.arvalid = 0;
        check("collide.rvalid", {bus.rvalid, bus.bvalid}, 2'b11);
        check("collide.rdata", bus.rdata, old);
        model_write(BASE + 20, 32'h0BAD_F00D, 4'hF, er);
        bus.bready = 1; bus.rready = 1; step(); bus.bready = 0; bus.rready = 0;
        do_read(BASE + 20, 0, "collide.new");

        // back-to-back reads with RREADY held high
        bus.rready = 1; bus.araddr = BASE + 28; bus.arvalid = 1;
        step();
        bus.araddr = BASE + 32;
        check("b2b.first", {bus.rvalid, bus.arready}, 2'b10);
        check("b2b.first_data", bus.rdata, ref_mem[7]);
        step();
        check("b2b.gap", {bus.rvalid, bus.arready}, 2'b01);
        step();
        bus.arvalid = 0;
        check("b2b.second", bus.rvalid, 1);
        check("b2b.second_data", bus.rdata, ref_mem[8]);
        step();
        bus.rready = 0;
        check("b2b.done", bus.rvalid, 0);

        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 7) a = BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(0, 3);
            else if (kind == 7) a = BASE + 32'h400 + $urandom_range(0, 3);
            else if (kind == 8) a = BASE + 32'h404 + 4 * $urandom_range(0, 1000);
            else a = BASE - 4 * $urandom_range(1, 1000);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)), "rnd_wr");
            else
                do_read(a, int'($urandom_range(0, 2)), "rnd_rd");
        end

        // asynchronous reset while a B response is pending and READY is set
        do_write(32'hB000_0400, 32'h0000_0001, 4'h1, 0, 0, "arst.ctrl");
        do_write(32'hB000_0400, 32'h0000_0001, 4'h1, 0, -1, "arst.pend");
        #2 rst_n = 0;
        #1;
        check("arst.bvalid", bus.bvalid, 0);
        check("arst.boot_rdy", boot_code_ready, 0);
        check("arst.ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
        ref_ready = 0;
        step(); step();
        rst_n = 1;
        step();
        for (int i = 0; i < 8; i++) do_read(BASE + 4 * $urandom_range(0, WORDS - 1), 0, "arst.ram");
        do_read(32'hB000_0400, 0, "arst.ctrl_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
